sd_fifo_tail_b: RTL and testbench
=================================

SD_FIFO_TAIL_B -- requirements
Module: sd_fifo_tail_b

Interface
REQ-001 Parameter: width, 8, data width in bits.
REQ-002 Parameter: depth, 16, maximum memory entries addressable.
REQ-003 Parameter: commit, 0, 1 enables read commit/abort (rewind) behaviour.
REQ-004 Parameter: asz, $clog2(depth), pointer width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  arbitration grant; no memory read is issued while low.
REQ-008 bound_low, bound_high  in  asz each  inclusive address ring limits, constant during operation.
REQ-009 wrptr  in  asz  committed write pointer from the FIFO head.
REQ-010 cur_rdptr  out  asz  next memory address to read.
REQ-011 com_rdptr  out  asz  committed read pointer, returned to head as its rdptr.
REQ-012 mem_re  out  1  memory read strobe; mem_rdaddr  out  asz  read address (equals cur_rdptr).
REQ-013 mem_rddata  in  width  memory read data, valid exactly one cycle after mem_re.
REQ-014 p_srdy  out  1, p_drdy  in  1, p_data  out  width: producer-side srdy/drdy handshake.
REQ-015 p_commit, p_abort  in  1 each: commit with a transfer; abort (asserted only when no transfer occurs).
REQ-016 p_usage  out  asz+1  entries between cur_rdptr and wrptr.

Function
REQ-017 Ring: ptr+1 SHALL wrap to bound_low when ptr == bound_high.
REQ-018 empty SHALL be (cur_rdptr == wrptr); no read issued while empty.
REQ-019 Output stage SHALL be a 2-entry buffer, each entry holding data and its source address; p_srdy = buffer non-empty; p_data = oldest entry.
REQ-020 pop = p_srdy & p_drdy; inflight = 1 in the cycle after mem_re unless discarded.
REQ-021 mem_re SHALL = enable & !empty & !abort_now & (occupancy + inflight - pop < 2); on mem_re cur_rdptr advances by REQ-017.
REQ-022 mem_rddata SHALL be written into the buffer at the end of the cycle after mem_re; first data visible on p_srdy 2 cycles after mem_re.
REQ-023 Sustained throughput SHALL be one transfer per cycle when non-empty, enable high and p_drdy high.
REQ-024 Buffer SHALL never overflow; simultaneous pop and capture in one cycle SHALL preserve ordering.
REQ-025 commit=0: com_rdptr SHALL equal cur_rdptr; p_commit, p_abort ignored.
REQ-026 commit=1: on pop & p_commit, com_rdptr SHALL become (popped entry address)+1 per REQ-017.
REQ-027 commit=1, p_abort high: next cycle cur_rdptr = com_rdptr, buffer emptied, in-flight read data discarded, no mem_re that cycle.
REQ-028 Abort SHALL take priority over any read issue; commit and abort never both act in one cycle.
REQ-029 p_usage SHALL = (wrptr - cur_rdptr) mod (bound_high - bound_low + 1), computed at asz+1 bits.
REQ-030 wrptr advancing while empty SHALL trigger mem_re in the same cycle (enable high, buffer space free).

Reset
REQ-031 On reset assertion (any time, asynchronously): cur_rdptr = com_rdptr = bound_low, buffer empty, p_srdy = 0, inflight cleared.
REQ-032 mem_re SHALL be 0 while reset is high; reset mid-transfer discards all buffered and in-flight data.

Verification
REQ-033 bounds 0..15, head writes 3 entries (wrptr 0->3), p_drdy=1 -> p_data in address order 0,1,2, one per cycle, first 2 cycles after first mem_re; p_usage 3->0.
REQ-034 bounds 4..7, 10 writes/reads streaming -> pointers wrap 7->4, data order preserved, no gaps with p_drdy=1.
REQ-035 p_drdy=0 with 5 entries available -> exactly 2 reads issued, p_srdy held, p_data stable; release p_drdy -> remaining 3 delivered in order.
REQ-036 commit=1: pop 2 without commit, abort -> cur_rdptr returns to bound_low, same 2 entries re-delivered; pop with p_commit -> com_rdptr = address+1.
REQ-037 Abort in the cycle after mem_re -> returning mem_rddata discarded, p_srdy=0 next cycle.
REQ-038 Reset asserted mid-stream with 2 buffered entries -> p_srdy=0 immediately, cur_rdptr=com_rdptr=bound_low.

Source files
------------

// File: rtl/sd_fifo_tail_b_if.sv
// Producer-side srdy/drdy handshake of the FIFO tail,
// including the commit/abort side-band used for rewindable reads.
interface sd_fifo_tail_b_if #(
    parameter int width = 8
);
    logic             p_srdy;
    logic             p_drdy;
    logic [width-1:0] p_data;
    logic             p_commit;
    logic             p_abort;

    modport master (
        output p_srdy,
        output p_data,
        input  p_drdy,
        input  p_commit,
        input  p_abort
    );

    modport slave (
        input  p_srdy,
        input  p_data,
        output p_drdy,
        output p_commit,
        output p_abort
    );
endinterface

// File: rtl/sd_fifo_tail_b.sv
// FIFO tail: issues memory reads into a 2-entry output buffer,
// with optional commit/abort rewind of the read pointer.
module sd_fifo_tail_b #(
    parameter int width  = 8,
    parameter int depth  = 16,
    parameter int commit = 0,
    parameter int asz    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [asz-1:0]   bound_low,
    input  logic [asz-1:0]   bound_high,
    input  logic [asz-1:0]   wrptr,
    output logic [asz-1:0]   cur_rdptr,
    output logic [asz-1:0]   com_rdptr,
    output logic             mem_re,
    output logic [asz-1:0]   mem_rdaddr,
    input  logic [width-1:0] mem_rddata,
    output logic [asz:0]     p_usage,
    sd_fifo_tail_b_if.master p
);

    localparam logic [asz-1:0] ONE = 1;

    function automatic logic [asz-1:0] ring_inc(
        input logic [asz-1:0] ptr,
        input logic [asz-1:0] lo,
        input logic [asz-1:0] hi
    );
        return (ptr == hi) ? lo : ptr + ONE;
    endfunction

    logic             commit_en;
    logic [asz-1:0]   com_r;
    logic [1:0]       cnt;
    logic             inflight;
    logic [asz-1:0]   inflight_addr;
    logic [width-1:0] buf_data [2];
    logic [asz-1:0]   buf_addr [2];

    logic             empty;
    logic             pop;
    logic             abort_now;
    logic             capture;
    logic             room;
    logic [2:0]       need;
    logic [2:0]       limit;

    logic [1:0]       base;
    logic [1:0]       nxt_cnt;
    logic [width-1:0] nxt_data [2];
    logic [asz-1:0]   nxt_addr [2];

    logic [asz:0]     span;
    logic [asz:0]     diff;

    assign commit_en = (commit != 0);

    assign empty     = (cur_rdptr == wrptr);
    assign pop       = p.p_srdy & p.p_drdy;
    assign abort_now = commit_en & p.p_abort;
    assign capture   = inflight & ~abort_now;

    // Count what the buffer will hold once the pending read lands.
    assign need  = {1'b0, cnt} + {2'b0, inflight};
    assign limit = 3'd2 + {2'b0, pop};
    assign room  = (need < limit);

    assign mem_re = ~reset & enable & ~empty
                  & ~abort_now & room;

    assign mem_rdaddr = cur_rdptr;
    assign com_rdptr  = commit_en ? com_r : cur_rdptr;

    assign p.p_srdy = (cnt != 2'd0);
    assign p.p_data = buf_data[0];

    always_comb begin
        nxt_data = buf_data;
        nxt_addr = buf_addr;
        base     = cnt - {1'b0, pop};
        if (pop) begin
            nxt_data[0] = buf_data[1];
            nxt_addr[0] = buf_addr[1];
        end
        if (capture) begin
            nxt_data[base[0]] = mem_rddata;
            nxt_addr[base[0]] = inflight_addr;
        end
        nxt_cnt = base + {1'b0, capture};
        if (abort_now) begin
            nxt_cnt = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_rdptr     <= bound_low;
            com_r         <= bound_low;
            cnt           <= 2'd0;
            inflight      <= 1'b0;
            inflight_addr <= bound_low;
        end else begin
            cnt      <= nxt_cnt;
            inflight <= mem_re;
            if (mem_re) begin
                inflight_addr <= cur_rdptr;
            end
            if (abort_now) begin
                cur_rdptr <= com_r;
            end else if (mem_re) begin
                cur_rdptr <= ring_inc(
                    cur_rdptr, bound_low, bound_high);
            end
            if (commit_en & pop & p.p_commit
                & ~abort_now) begin
                com_r <= ring_inc(
                    buf_addr[0], bound_low, bound_high);
            end
        end
    end

    // Payload needs no reset; validity lives in cnt.
    always_ff @(posedge clk) begin
        buf_data <= nxt_data;
        buf_addr <= nxt_addr;
    end

    always_comb begin
        span = {1'b0, bound_high} - {1'b0, bound_low}
             + {{asz{1'b0}}, 1'b1};
        diff = {1'b0, wrptr} - {1'b0, cur_rdptr};
        if (wrptr < cur_rdptr) begin
            diff = diff + span;
        end
        p_usage = diff;
    end

endmodule

// File: tb/tb_sd_fifo_tail_b.sv
// Directed bench for sd_fifo_tail_b: one plain instance and
// one commit-enabled instance sharing clock, bounds and wrptr.
module tb_sd_fifo_tail_b;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] bl, bh, wrptr;

    logic [3:0] cur0, com0, addr0;
    logic [3:0] cur1, com1, addr1;
    logic       re0, re1;
    logic [7:0] rd0, rd1;
    logic [4:0] use0, use1;

    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    sd_fifo_tail_b_if #(.width(8)) p ();
    sd_fifo_tail_b_if #(.width(8)) pc ();

    sd_fifo_tail_b #(
        .width(8), .depth(16), .commit(0), .asz(4)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .bound_low(bl), .bound_high(bh), .wrptr(wrptr),
        .cur_rdptr(cur0), .com_rdptr(com0),
        .mem_re(re0), .mem_rdaddr(addr0),
        .mem_rddata(rd0), .p_usage(use0), .p(p)
    );

    sd_fifo_tail_b #(
        .width(8), .depth(16), .commit(1), .asz(4)
    ) u_cdut (
        .clk(clk), .reset(reset), .enable(enable),
        .bound_low(bl), .bound_high(bh), .wrptr(wrptr),
        .cur_rdptr(cur1), .com_rdptr(com1),
        .mem_re(re1), .mem_rdaddr(addr1),
        .mem_rddata(rd1), .p_usage(use1), .p(pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (re0) rd0 <= mem[addr0];
        if (re1) rd1 <= mem[addr1];
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        wrptr = 4'd3;
        #1;
        checks++; if (cur0 !== 4'd0) begin errors++; $display("FAIL reset_cur0 got %0d exp 0", cur0); end
        checks++; if (com0 !== 4'd0) begin errors++; $display("FAIL reset_com0 got %0d exp 0", com0); end
        checks++; if (p.p_srdy !== 1'b0) begin errors++; $display("FAIL reset_srdy0 got %b exp 0", p.p_srdy); end
        checks++; if (re0 !== 1'b0) begin errors++; $display("FAIL reset_re0 got %b exp 0", re0); end
        checks++; if (cur1 !== 4'd0) begin errors++; $display("FAIL reset_cur1 got %0d exp 0", cur1); end
        checks++; if (com1 !== 4'd0) begin errors++; $display("FAIL reset_com1 got %0d exp 0", com1); end
        checks++; if (pc.p_srdy !== 1'b0) begin errors++; $display("FAIL reset_srdy1 got %b exp 0", pc.p_srdy); end
        checks++; if (use0 !== 5'd3) begin errors++; $display("FAIL reset_usage got %0d exp 3", use0); end
        @(negedge clk);
        wrptr = 4'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit         e_re   [6] = '{1, 1, 1, 0, 0, 0};
        bit         e_srdy [6] = '{0, 0, 1, 1, 1, 0};
        logic [3:0] e_cur  [6] = '{0, 1, 2, 3, 3, 3};
        logic [4:0] e_use  [6] = '{3, 2, 1, 0, 0, 0};
        logic [7:0] e_data [6] = '{0, 0, 8'hA0, 8'hA1, 8'hA2, 0};
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        for (int i = 0; i < 3; i++) mem[i] = 8'(8'hA0 + i);
        do_reset();
        p.p_drdy = 1'b1;
        p.p_abort = 1'b1;
        p.p_commit = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) wrptr = 4'd3;
            #1;
            checks++; if (re0 !== e_re[c]) begin errors++; $display("FAIL basic_re c%0d got %b exp %b", c, re0, e_re[c]); end
            if (e_re[c]) begin
                checks++; if (addr0 !== 4'(c)) begin errors++; $display("FAIL basic_addr c%0d got %0d exp %0d", c, addr0, c); end
            end
            checks++; if (p.p_srdy !== e_srdy[c]) begin errors++; $display("FAIL basic_srdy c%0d got %b exp %b", c, p.p_srdy, e_srdy[c]); end
            if (e_srdy[c]) begin
                checks++; if (p.p_data !== e_data[c]) begin errors++; $display("FAIL basic_data c%0d got %h exp %h", c, p.p_data, e_data[c]); end
            end
            checks++; if (use0 !== e_use[c]) begin errors++; $display("FAIL basic_usage c%0d got %0d exp %0d", c, use0, e_use[c]); end
            checks++; if (cur0 !== e_cur[c]) begin errors++; $display("FAIL basic_cur c%0d got %0d exp %0d", c, cur0, e_cur[c]); end
            checks++; if (com0 !== e_cur[c]) begin errors++; $display("FAIL basic_com c%0d got %0d exp %0d", c, com0, e_cur[c]); end
        end
        p.p_abort = 1'b0;
        p.p_commit = 1'b0;
    endtask

    task automatic test_enable();
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wrptr = 4'd2;
            enable = (c == 2);
            #1;
            checks++; if (re0 !== (c == 2)) begin errors++; $display("FAIL enable_re c%0d got %b exp %b", c, re0, (c == 2)); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] e_cur;
        bl = 4'd4; bh = 4'd7; wrptr = 4'd4;
        do_reset();
        p.p_drdy = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 10) begin
                mem[wrptr] = 8'(8'h50 + c);
                wrptr = (wrptr == 4'd7) ? 4'd4 : wrptr + 4'd1;
            end
            #1;
            e_cur = (c < 10) ? 4'(4 + c % 4) : 4'd6;
            checks++; if (re0 !== (c < 10)) begin errors++; $display("FAIL wrap_re c%0d got %b exp %b", c, re0, (c < 10)); end
            checks++; if (cur0 !== e_cur) begin errors++; $display("FAIL wrap_cur c%0d got %0d exp %0d", c, cur0, e_cur); end
            checks++; if (use0 !== ((c < 10) ? 5'd1 : 5'd0)) begin errors++; $display("FAIL wrap_usage c%0d got %0d", c, use0); end
            checks++; if (p.p_srdy !== (c >= 2 && c < 12)) begin errors++; $display("FAIL wrap_srdy c%0d got %b exp %b", c, p.p_srdy, (c >= 2 && c < 12)); end
            if (c >= 2 && c < 12) begin
                checks++; if (p.p_data !== 8'(8'h50 + c - 2)) begin errors++; $display("FAIL wrap_data c%0d got %h exp %h", c, p.p_data, 8'(8'h50 + c - 2)); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        for (int i = 0; i < 5; i++) mem[i] = 8'(8'hC0 + i);
        do_reset();
        p.p_drdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) wrptr = 4'd5;
            #1;
            if (re0) n++;
            if (c >= 2) begin
                checks++; if (p.p_srdy !== 1'b1) begin errors++; $display("FAIL bp_srdy c%0d got %b exp 1", c, p.p_srdy); end
                checks++; if (p.p_data !== 8'hC0) begin errors++; $display("FAIL bp_data c%0d got %h exp c0", c, p.p_data); end
            end
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL bp_reads got %0d exp 2", n); end
        checks++; if (use0 !== 5'd3) begin errors++; $display("FAIL bp_usage got %0d exp 3", use0); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            p.p_drdy = 1'b1;
            #1;
            checks++; if (p.p_srdy !== (c < 5)) begin errors++; $display("FAIL bp_rel_srdy c%0d got %b exp %b", c, p.p_srdy, (c < 5)); end
            if (c < 5) begin
                checks++; if (p.p_data !== 8'(8'hC0 + c)) begin errors++; $display("FAIL bp_rel_data c%0d got %h exp %h", c, p.p_data, 8'(8'hC0 + c)); end
            end
        end
        p.p_drdy = 1'b0;
    endtask

    task automatic test_commit_abort();
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        for (int i = 0; i < 6; i++) mem[i] = 8'(8'hD0 + i);
        do_reset();
        pc.p_drdy = 1'b1;
        @(negedge clk); wrptr = 4'd6; #1;
        checks++; if (re1 !== 1'b1) begin errors++; $display("FAIL ca_re0 got %b exp 1", re1); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (pc.p_data !== 8'hD0) begin errors++; $display("FAIL ca_d0 got %h exp d0", pc.p_data); end
        @(negedge clk); #1;
        checks++; if (pc.p_data !== 8'hD1) begin errors++; $display("FAIL ca_d1 got %h exp d1", pc.p_data); end
        checks++; if (com1 !== 4'd0) begin errors++; $display("FAIL ca_com_pre got %0d exp 0", com1); end
        @(negedge clk);
        pc.p_drdy = 1'b0;
        pc.p_abort = 1'b1;
        #1;
        checks++; if (re1 !== 1'b0) begin errors++; $display("FAIL ca_abort_re got %b exp 0", re1); end
        checks++; if (pc.p_data !== 8'hD2) begin errors++; $display("FAIL ca_abort_data got %h exp d2", pc.p_data); end
        @(negedge clk);
        pc.p_abort = 1'b0;
        pc.p_drdy = 1'b1;
        #1;
        checks++; if (cur1 !== 4'd0) begin errors++; $display("FAIL ca_rewind_cur got %0d exp 0", cur1); end
        checks++; if (pc.p_srdy !== 1'b0) begin errors++; $display("FAIL ca_rewind_srdy got %b exp 0", pc.p_srdy); end
        checks++; if (re1 !== 1'b1) begin errors++; $display("FAIL ca_rewind_re got %b exp 1", re1); end
        @(negedge clk);
        @(negedge clk);
        pc.p_commit = 1'b1;
        #1;
        checks++; if (pc.p_data !== 8'hD0) begin errors++; $display("FAIL ca_redeliver got %h exp d0", pc.p_data); end
        checks++; if (com1 !== 4'd0) begin errors++; $display("FAIL ca_com_hold got %0d exp 0", com1); end
        @(negedge clk);
        pc.p_commit = 1'b0;
        #1;
        checks++; if (com1 !== 4'd1) begin errors++; $display("FAIL ca_com_post got %0d exp 1", com1); end
        checks++; if (pc.p_data !== 8'hD1) begin errors++; $display("FAIL ca_redeliver2 got %h exp d1", pc.p_data); end
        pc.p_drdy = 1'b0;
    endtask

    task automatic test_abort_inflight();
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        do_reset();
        pc.p_drdy = 1'b1;
        @(negedge clk); wrptr = 4'd6; #1;
        checks++; if (re1 !== 1'b1) begin errors++; $display("FAIL ai_re got %b exp 1", re1); end
        @(negedge clk); pc.p_abort = 1'b1; #1;
        checks++; if (re1 !== 1'b0) begin errors++; $display("FAIL ai_abort_re got %b exp 0", re1); end
        @(negedge clk); pc.p_abort = 1'b0; #1;
        checks++; if (pc.p_srdy !== 1'b0) begin errors++; $display("FAIL ai_srdy_a got %b exp 0", pc.p_srdy); end
        checks++; if (cur1 !== 4'd0) begin errors++; $display("FAIL ai_cur got %0d exp 0", cur1); end
        @(negedge clk); #1;
        checks++; if (pc.p_srdy !== 1'b0) begin errors++; $display("FAIL ai_srdy_b got %b exp 0", pc.p_srdy); end
        @(negedge clk); #1;
        checks++; if (pc.p_data !== 8'hD0 || pc.p_srdy !== 1'b1) begin errors++; $display("FAIL ai_data got %h/%b exp d0/1", pc.p_data, pc.p_srdy); end
        pc.p_drdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        for (int i = 0; i < 5; i++) mem[i] = 8'(8'hE0 + i);
        do_reset();
        p.p_drdy = 1'b0;
        @(negedge clk); wrptr = 4'd5;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (p.p_srdy !== 1'b1) begin errors++; $display("FAIL rm_pre_srdy got %b exp 1", p.p_srdy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (p.p_srdy !== 1'b0) begin errors++; $display("FAIL rm_srdy got %b exp 0", p.p_srdy); end
        checks++; if (cur0 !== 4'd0) begin errors++; $display("FAIL rm_cur got %0d exp 0", cur0); end
        checks++; if (com0 !== 4'd0) begin errors++; $display("FAIL rm_com got %0d exp 0", com0); end
        checks++; if (re0 !== 1'b0) begin errors++; $display("FAIL rm_re got %b exp 0", re0); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (re0 !== 1'b1 || p.p_srdy !== 1'b0) begin errors++; $display("FAIL rm_restart got re %b srdy %b exp 1/0", re0, p.p_srdy); end
        @(negedge clk); #1;
        checks++; if (p.p_srdy !== 1'b0) begin errors++; $display("FAIL rm_gap got %b exp 0", p.p_srdy); end
        @(negedge clk); #1;
        checks++; if (p.p_data !== 8'hE0 || p.p_srdy !== 1'b1) begin errors++; $display("FAIL rm_data got %h/%b exp e0/1", p.p_data, p.p_srdy); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        bl = 4'd0; bh = 4'd15; wrptr = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        p.p_drdy = 1'b0; p.p_commit = 1'b0; p.p_abort = 1'b0;
        pc.p_drdy = 1'b0; pc.p_commit = 1'b0; pc.p_abort = 1'b0;
        test_reset();
        test_basic();
        test_enable();
        test_wrap();
        test_backpressure();
        test_commit_abort();
        test_abort_inflight();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
